// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction fetch stage for processor Z.
//
// Owns the program counter and the single RAM port, which it shares with an
// external loader. While running it issues at most one read per cycle and
// buffers the returned words, tagged with their addresses, in a DEPTH-entry
// queue that decode drains over a valid/ready handshake. A redirect flushes
// the queue and restarts fetch at a new address. A word whose top byte is
// 8'h00 is a HALT: it is delivered, and fetching stops until the next redirect.
//
// Ports
//   clock, reset       rising-edge clock, synchronous active-high reset
//   working            1 = fetch owns the RAM port, 0 = loader owns it
//   ext_addr/wr/wdata  loader access, passed to the RAM while IDLE
//   mem_addr/wr/wdata  RAM port outputs
//   mem_rd             read issued this cycle; mem_rdata returns one cycle later
//   mem_rdata          RAM read data
//   redirect           flush the queue and restart fetch at redirect_pc
//   out_valid/ready    decode handshake for the head entry
//   out_instr, out_pc  head instruction word and its address
//   halted             fetch stopped on a HALT word
//
// Optional feature macro: IFQ_BYPASS_EN
//   Defined: a word returning into an empty queue is shown on out_* in its
//   capture cycle, and is not enqueued if decode takes it in that cycle.
//   Undefined: every word passes through the queue and out_* come from
//   registers only.

module ifetch_queue #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              working,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic              ext_wr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              halted
);

   // state | meaning
   // IDLE  | loader owns the RAM port, no fetch issued
   // RUN   | fetching one word per cycle while the queue has credit
   // HALT  | HALT word captured, fetch stopped until a redirect

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetchState_t;

   fetchState_t       state;
   fetchState_t       stateNext;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] qInstr [DEPTH];
   logic [ADDR_W-1:0] qPc    [DEPTH];
   logic [PTR_W-1:0]  headPtr;
   logic [PTR_W-1:0]  tailPtr;
   logic [CNT_W-1:0]  count;
   logic              inflight;
   logic [ADDR_W-1:0] inflightPc;
   logic [DATA_W-1:0] lastInstr;
   logic [ADDR_W-1:0] lastPc;

   logic [CNT_W-1:0]  creditUsed;
   logic              issue;
   logic              capture;
   logic              isHaltWord;
   logic              flush;
   logic              queueValid;
   logic              popQueue;
   logic              push;

   // A queue slot is reserved for every read in flight, so a capture can
   // never find the queue full.
   always_comb begin
      creditUsed = count + CNT_W'(inflight);
      issue      = (state == RUN) && !redirect && (creditUsed < CNT_W'(DEPTH));
      capture    = inflight && !redirect && (state != HALT);
      isHaltWord = (mem_rdata[DATA_W-1 -: 8] == 8'h00);
      flush      = redirect && (state != IDLE);
      queueValid = (count != '0);
      popQueue   = queueValid && out_ready;
   end

   // When nothing is presentable, out_* hold whatever was shown last cycle.
`ifdef IFQ_BYPASS_EN
   logic bypassHit;

   always_comb begin
      bypassHit = capture && !queueValid;
      push      = capture && !(bypassHit && out_ready);
      out_valid = queueValid || bypassHit;
      if (queueValid) begin
         out_instr = qInstr[headPtr];
         out_pc    = qPc[headPtr];
      end else if (bypassHit) begin
         out_instr = mem_rdata;
         out_pc    = inflightPc;
      end else begin
         out_instr = lastInstr;
         out_pc    = lastPc;
      end
   end
`else
   always_comb begin
      push      = capture;
      out_valid = queueValid;
      out_instr = queueValid ? qInstr[headPtr] : lastInstr;
      out_pc    = queueValid ? qPc[headPtr]    : lastPc;
   end
`endif

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (working) stateNext = RUN;
         end
         RUN: begin
            if (!working)                    stateNext = IDLE;
            else if (capture && isHaltWord)  stateNext = HALT;
         end
         HALT: begin
            if (!working)     stateNext = IDLE;
            else if (redirect) stateNext = RUN;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      mem_wdata = ext_wdata;
      mem_rd    = issue;
      halted    = (state == HALT);
      if (state == IDLE) begin
         mem_addr = ext_addr;
         mem_wr   = ext_wr;
      end else begin
         mem_addr = pc;
         mem_wr   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         pc         <= '0;
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
         inflight   <= 1'b0;
         inflightPc <= '0;
         lastInstr  <= '0;
         lastPc     <= '0;
      end else begin
         state     <= stateNext;
         inflight  <= issue;
         lastInstr <= out_instr;
         lastPc    <= out_pc;
         if (issue) inflightPc <= pc;

         if (redirect)   pc <= redirect_pc;
         else if (issue) pc <= pc + ADDR_W'(1);

         // A handshake in the redirect cycle still completes; the flush
         // then discards everything that is left.
         if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
         end else begin
            if (push)     tailPtr <= tailPtr + PTR_W'(1);
            if (popQueue) headPtr <= headPtr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(popQueue);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         qInstr[tailPtr] <= mem_rdata;
         qPc[tailPtr]    <= inflightPc;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int MEMSZ  = 512;
`ifdef IFQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic              working;
   logic [ADDR_W-1:0] ext_addr;
   logic              ext_wr;
   logic [DATA_W-1:0] ext_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic [DATA_W-1:0] mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;

   always #5 clock = ~clock;

   ifetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .working(working),
      .ext_addr(ext_addr), .ext_wr(ext_wr), .ext_wdata(ext_wdata),
      .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
   );

   // RAM attached to the DUT port
   logic [DATA_W-1:0] ram [MEMSZ];
   always @(posedge clock) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
   end

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;
   bit checkEn     = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [8:0]  pc;
   } entry_t;

   typedef struct {
      int          cyc;
      logic [8:0]  pc;
      logic [31:0] instr;
   } logEnt_t;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [8:0]  addr;
      bit          valid;
      logic [31:0] instr;
      logic [8:0]  pc;
      bit          halted;
      bit          capture;
      bit          bypass;
   } exp_t;

   entry_t      mQ[$];
   logEnt_t     outLog[$];
   logic [31:0] golden [MEMSZ];
   int          mMode = 0;         // 0 idle, 1 run, 2 halt
   int          mPc = 0;
   bit          mInflight = 0;
   int          mInPc = 0;
   logic [31:0] mLastInstr = '0;
   logic [8:0]  mLastPc = '0;

   function automatic exp_t predict();
      exp_t e;
      int inUse;
      inUse     = mQ.size() + (mInflight ? 1 : 0);
      e.capture = mInflight && !redirect && (mMode != 2);
      e.bypass  = 0;
`ifdef IFQ_BYPASS_EN
      e.bypass  = e.capture && (mQ.size() == 0);
`endif
      e.rd     = (mMode == 1) && !redirect && (inUse < DEPTH);
      e.wr     = (mMode == 0) ? ext_wr : 1'b0;
      e.addr   = (mMode == 0) ? ext_addr : 9'(mPc);
      e.halted = (mMode == 2);
      if (mQ.size() > 0) begin
         e.valid = 1; e.instr = mQ[0].instr; e.pc = mQ[0].pc;
      end else if (e.bypass) begin
         e.valid = 1; e.instr = golden[mInPc]; e.pc = 9'(mInPc);
      end else begin
         e.valid = 0; e.instr = mLastInstr; e.pc = mLastPc;
      end
      return e;
   endfunction

   always @(posedge clock) begin
      exp_t        e;
      logic [31:0] w;
      entry_t      ent;
      e = predict();
      cyc++;
      if (reset) begin
         mQ.delete();
         mPc = 0; mInflight = 0; mInPc = 0;
         mLastInstr = '0; mLastPc = '0; mMode = 0;
      end else begin
         w = golden[mInPc];
         if (e.valid && out_ready) begin
            outLog.push_back('{cyc: cyc, pc: e.pc, instr: e.instr});
            if (mQ.size() > 0) void'(mQ.pop_front());
         end
         if (e.capture && !(e.bypass && out_ready)) begin
            ent.instr = w; ent.pc = 9'(mInPc);
            mQ.push_back(ent);
         end
         if (redirect && mMode != 0) mQ.delete();
         mLastInstr = e.instr;
         mLastPc    = e.pc;
         if (mMode == 0 && ext_wr) golden[ext_addr] = ext_wdata;
         if (e.rd) mInPc = mPc;
         mInflight = e.rd;
         if (redirect)  mPc = int'(redirect_pc);
         else if (e.rd) mPc = (mPc + 1) % MEMSZ;
         case (mMode)
            0: if (working) mMode = 1;
            1: if (!working) mMode = 0;
               else if (e.capture && w[31:24] == 8'h00) mMode = 2;
            default: if (!working) mMode = 0;
                     else if (redirect) mMode = 1;
         endcase
      end
   end

   // single compare process
   always @(negedge clock) begin
      exp_t e;
      if (checkEn) begin
         e = predict();
         chk("mem_rd",    32'(mem_rd),    32'(e.rd));
         chk("mem_wr",    32'(mem_wr),    32'(e.wr));
         chk("mem_addr",  32'(mem_addr),  32'(e.addr));
         chk("out_valid", 32'(out_valid), 32'(e.valid));
         chk("out_instr", out_instr,      e.instr);
         chk("out_pc",    32'(out_pc),    32'(e.pc));
         chk("halted",    32'(halted),    32'(e.halted));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic load(int a, logic [31:0] d);
      ext_addr = 9'(a); ext_wr = 1'b1; ext_wdata = d;
      step(1);
      ext_wr = 1'b0;
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] prog [4];
      int issueAt, validAt, nIssue, stale, n;
      bit found;

      prog[0] = 32'h10F00080; prog[1] = 32'h10F10081;
      prog[2] = 32'h20010000; prog[3] = 32'h23670000;

      reset = 1; working = 0; ext_addr = '0; ext_wr = 0; ext_wdata = '0;
      redirect = 0; redirect_pc = '0; out_ready = 1;
      step(2);
      reset = 0;
      checkEn = 1;

      // reset state
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_mem_rd", 32'(mem_rd), 0);

      // preload the whole RAM with non-HALT words, then the test program
      for (int i = 0; i < MEMSZ; i++)
         load(i, {8'($urandom_range(1, 255)), 24'($urandom)});
      for (int i = 0; i < 4; i++) load(i, prog[i]);

      // test 1: streaming fetch, latency and order
      working = 1; out_ready = 1;
      outLog.delete();
      issueAt = -1; validAt = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (mem_rd && issueAt < 0) issueAt = k;
         if (out_valid && validAt < 0) validAt = k;
         step(1);
      end
      chk("t1_latency", 32'(validAt - issueAt), LAT);
      chk("t1_log_ge4", 32'(outLog.size() >= 4), 1);
      for (int i = 0; i < 4 && i < outLog.size(); i++) begin
         chk("t1_instr", outLog[i].instr, prog[i]);
         chk("t1_pc", 32'(outLog[i].pc), 32'(i));
         chk("t1_back_to_back", 32'(outLog[i].cyc - outLog[0].cyc), 32'(i));
      end

      // test 2: stall fills exactly DEPTH entries, then drains without gaps
      pulseReset();
      out_ready = 0;
      nIssue = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (mem_rd) nIssue++;
         step(1);
      end
      chk("t2_issues", 32'(nIssue), DEPTH);
      chk("t2_rd_stalled", 32'(mem_rd), 0);
      chk("t2_pc", 32'(mem_addr), 4);
      chk("t2_head_pc", 32'(out_pc), 0);
      outLog.delete();
      out_ready = 1;
      step(12);
      chk("t2_log_ge8", 32'(outLog.size() >= 8), 1);
      for (int i = 0; i < 8 && i < outLog.size(); i++)
         chk("t2_seq_pc", 32'(outLog[i].pc), 32'(i));

      // test 3: redirect with 3 queued and 1 in flight
      pulseReset();
      out_ready = 0;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         step(1);
         if (mQ.size() == 3 && mInflight) found = 1;
      end
      chk("t3_setup_reached", 32'(found), 1);
      redirect = 1; redirect_pc = 9'd9;
      outLog.delete();
      step(1);
      redirect = 0; out_ready = 1;
      step(8);
      stale = 0;
      foreach (outLog[i]) if (outLog[i].pc < 9) stale++;
      chk("t3_no_stale", 32'(stale), 0);
      chk("t3_log_ge2", 32'(outLog.size() >= 2), 1);
      if (outLog.size() >= 2) begin
         chk("t3_first_pc", 32'(outLog[0].pc), 9);
         chk("t3_second_pc", 32'(outLog[1].pc), 10);
      end

      // test 4: HALT word at address 5
      working = 0;
      pulseReset();
      load(5, 32'h00000000);
      outLog.delete();
      working = 1; out_ready = 1;
      step(14);
      chk("t4_halted", 32'(halted), 1);
      chk("t4_rd_off", 32'(mem_rd), 0);
      chk("t4_log_size", 32'(outLog.size()), 6);
      n = outLog.size();
      if (n > 0) begin
         chk("t4_last_pc", 32'(outLog[n-1].pc), 5);
         chk("t4_last_instr", outLog[n-1].instr, 32'h0);
      end
      stale = 0;
      foreach (outLog[i]) if (outLog[i].pc == 9'd6) stale++;
      chk("t4_no_pc6", 32'(stale), 0);
      redirect = 1; redirect_pc = 9'd0;
      outLog.delete();
      step(1);
      redirect = 0;
      chk("t4_resumed", 32'(halted), 0);
      step(4);
      chk("t4_log_ge1", 32'(outLog.size() >= 1), 1);
      if (outLog.size() >= 1) begin
         chk("t4_resume_pc", 32'(outLog[0].pc), 0);
         chk("t4_resume_instr", outLog[0].instr, 32'h10F00080);
      end
      working = 0;
      step(3);
      load(5, 32'h55AA0005);

      // test 5: PC wrap 511 -> 0
      working = 1;
      step(2);
      out_ready = 0;
      redirect = 1; redirect_pc = 9'd510;
      step(1);
      redirect = 0;
      outLog.delete();
      out_ready = 1;
      step(8);
      chk("t5_log_ge4", 32'(outLog.size() >= 4), 1);
      for (int i = 0; i < 4 && i < outLog.size(); i++)
         chk("t5_wrap_pc", 32'(outLog[i].pc), 32'((510 + i) % MEMSZ));

      // test 6: reset with a full queue
      out_ready = 0;
      step(8);
      chk("t6_full_valid", 32'(out_valid), 1);
      pulseReset();
      chk("t6_valid_cleared", 32'(out_valid), 0);
      chk("t6_rd_idle", 32'(mem_rd), 0);
      step(1);
      chk("t6_pc_zero", 32'(mem_addr), 0);
      chk("t6_rd_run", 32'(mem_rd), 1);

      // plant a few HALT words, then randomised traffic
      working = 0;
      step(3);
      for (int i = 0; i < 6; i++) load($urandom_range(0, MEMSZ - 1), {8'h00, 24'($urandom)});
      working = 1;
      for (int c = 0; c < 4000; c++) begin
         out_ready   = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 99) < 4);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 9'(508 + $urandom_range(0, 3)) : 9'($urandom);
         if (working && $urandom_range(0, 149) == 0) working = 0;
         else if (!working && $urandom_range(0, 5) == 0) working = 1;
         ext_wr    = ($urandom_range(0, 3) == 0);
         ext_addr  = 9'($urandom);
         ext_wdata = ($urandom_range(0, 15) == 0) ? {8'h00, 24'($urandom)}
                                                  : {8'($urandom_range(1, 255)), 24'($urandom)};
         reset     = ($urandom_range(0, 499) == 0);
         step(1);
      end
      reset = 0; redirect = 0; ext_wr = 0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
